// File: rtl/pool_window2x2_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pool_window2x2_if : pixel stream in, 2x2 window strobe out
// Rev 1.0
// ------------------------------------------------------------------
interface pool_window2x2_if #(
  parameter int WIDTH = 9
);
  logic                    in_valid;
  logic                    in_sof;
  logic signed [WIDTH-1:0] in_data;
  logic                    win_valid;
  logic                    win_last;
  logic signed [WIDTH-1:0] a00;
  logic signed [WIDTH-1:0] a01;
  logic signed [WIDTH-1:0] a10;
  logic signed [WIDTH-1:0] a11;

  modport master (
    output in_valid, in_sof, in_data,
    input  win_valid, win_last, a00, a01, a10, a11
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output win_valid, win_last, a00, a01, a10, a11
  );
endinterface
`default_nettype wire

// File: rtl/pool_window2x2.sv
`default_nettype none
// ------------------------------------------------------------------
// pool_window2x2 : raster-stream 2x2 stride-2 window former
// Rev 1.0
// ------------------------------------------------------------------
module pool_window2x2 #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  pool_window2x2_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]           col_q, col_d, pos_col, col_prev;
  logic [RW-1:0]           row_q, row_d, pos_row;
  logic                    last_col, last_row;
  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic signed [WIDTH-1:0] a00_q, a00_d, a01_q, a01_d;
  logic signed [WIDTH-1:0] a10_q, a10_d, a11_q, a11_d;
  logic                    win_valid_q, win_valid_d;
  logic                    win_last_q, win_last_d;
  logic                    lb_we;
  logic signed [WIDTH-1:0] lb_mem [IMG_W];

  always_comb begin
    // SOF overrides the counters so a stray frame start realigns at once
    pos_col     = bus.in_sof ? '0 : col_q;
    pos_row     = bus.in_sof ? '0 : row_q;
    col_prev    = pos_col - CW'(1);
    last_col    = (pos_col == CW'(IMG_W - 1));
    last_row    = (pos_row == RW'(IMG_H - 1));
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    a00_d       = a00_q;
    a01_d       = a01_q;
    a10_d       = a10_q;
    a11_d       = a11_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    lb_we       = 1'b0;
    if (bus.in_valid) begin
      col_d = last_col ? '0 : pos_col + CW'(1);
      row_d = pos_row;
      if (last_col) begin
        row_d = last_row ? '0 : pos_row + RW'(1);
      end
      if (!pos_row[0]) begin
        lb_we = 1'b1;
      end else if (!pos_col[0]) begin
        hold_d = bus.in_data;
      end else begin
        a00_d       = lb_mem[col_prev];
        a01_d       = lb_mem[pos_col];
        a10_d       = hold_q;
        a11_d       = bus.in_data;
        win_valid_d = 1'b1;
        win_last_d  = last_row && last_col;
      end
    end
  end

  // Line buffer is written before it is read within a frame, so no reset
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_mem[pos_col] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      a00_q       <= '0;
      a01_q       <= '0;
      a10_q       <= '0;
      a11_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      a00_q       <= a00_d;
      a01_q       <= a01_d;
      a10_q       <= a10_d;
      a11_q       <= a11_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.a00       = a00_q;
  assign bus.a01       = a01_q;
  assign bus.a10       = a10_q;
  assign bus.a11       = a11_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_window2x2.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pool_window2x2 : random-stimulus bench, 4x4 and 6x2 instances
// Rev 1.0
// ------------------------------------------------------------------
module tb_pool_window2x2;

  localparam int WIDTH = 9;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       v     = 1'b0;
  logic       s     = 1'b0;
  logic [8:0] dat   = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pool_window2x2_if #(.WIDTH(WIDTH)) ifa ();
  pool_window2x2_if #(.WIDTH(WIDTH)) ifb ();

  assign ifa.in_valid = v;
  assign ifa.in_sof   = s;
  assign ifa.in_data  = dat;
  assign ifb.in_valid = v;
  assign ifb.in_sof   = s;
  assign ifb.in_data  = dat;

  pool_window2x2 #(.WIDTH(WIDTH), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  pool_window2x2 #(.WIDTH(WIDTH), .IMG_W(6), .IMG_H(2)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  // Reference: pixels land in a 2-D image by linear index within the frame
  int          pidx [2];
  logic [8:0]  img  [2][4][6];
  logic [8:0]  ea   [2][4];
  logic        exp_v [2];
  logic        exp_l [2];
  logic [36:0] log0 [$];
  logic [36:0] log1 [$];

  task automatic model_reset(int d);
    pidx[d]  = 0;
    exp_v[d] = 1'b0;
    exp_l[d] = 1'b0;
    for (int k = 0; k < 4; k++) ea[d][k] = '0;
  endtask

  task automatic model_step(int d, int w, int h);
    int r, c;
    exp_v[d] = 1'b0;
    exp_l[d] = 1'b0;
    if (v) begin
      if (s) pidx[d] = 0;
      r = pidx[d] / w;
      c = pidx[d] % w;
      img[d][r][c] = dat;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_v[d] = 1'b1;
        ea[d][0] = img[d][r-1][c-1];
        ea[d][1] = img[d][r-1][c];
        ea[d][2] = img[d][r][c-1];
        ea[d][3] = dat;
        exp_l[d] = (pidx[d] == w * h - 1);
        if (d == 0) log0.push_back({ea[d][0], ea[d][1], ea[d][2], ea[d][3], exp_l[d]});
        else        log1.push_back({ea[d][0], ea[d][1], ea[d][2], ea[d][3], exp_l[d]});
      end
      pidx[d] = (pidx[d] + 1) % (w * h);
    end
  endtask

  task automatic cmp(int d, logic wv, logic wl, logic [8:0] x0, logic [8:0] x1,
                     logic [8:0] x2, logic [8:0] x3);
    checks++;
    if ({wv, wl, x0, x1, x2, x3} !== {exp_v[d], exp_l[d], ea[d][0], ea[d][1], ea[d][2], ea[d][3]}) begin
      errors++;
      $display("FAIL cycle_cmp dut%0d t=%0t got v=%b l=%b %h %h %h %h want v=%b l=%b %h %h %h %h",
               d, $time, wv, wl, x0, x1, x2, x3,
               exp_v[d], exp_l[d], ea[d][0], ea[d][1], ea[d][2], ea[d][3]);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset(0);
    else        model_step(0, 4, 4);
    #1;
    cmp(0, ifa.win_valid, ifa.win_last, ifa.a00, ifa.a01, ifa.a10, ifa.a11);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset(1);
    else        model_step(1, 6, 2);
    #1;
    cmp(1, ifb.win_valid, ifb.win_last, ifb.a00, ifb.a01, ifb.a10, ifb.a11);
  end

  task automatic expect_eq(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [36:0] pk(int a, int b, int c, int e, bit l);
    return {a[8:0], b[8:0], c[8:0], e[8:0], l};
  endfunction

  task automatic pix(logic [8:0] d, logic sf);
    @(negedge clk);
    v   = 1'b1;
    s   = sf;
    dat = d;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      v   = 1'b0;
      s   = 1'b0;
      dat = 9'($urandom);
    end
  endtask

  task automatic frame(int n, int base, bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      pix(9'(base + i), i == 0);
    end
    idle(2);
  endtask

  task automatic check_frame1(string tag);
    expect_eq({tag, "_count"}, log0.size(), 4);
    expect_eq({tag, "_w0"}, log0[0], pk(0, 1, 4, 5, 0));
    expect_eq({tag, "_w1"}, log0[1], pk(2, 3, 6, 7, 0));
    expect_eq({tag, "_w2"}, log0[2], pk(8, 9, 12, 13, 0));
    expect_eq({tag, "_w3"}, log0[3], pk(10, 11, 14, 15, 1));
  endtask

  logic [8:0] t3 [16];

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    expect_eq("rst_outs4", {ifa.win_valid, ifa.win_last, ifa.a00, ifa.a01, ifa.a10, ifa.a11}, 0);
    expect_eq("rst_outs6", {ifb.win_valid, ifb.win_last, ifb.a00, ifb.a01, ifb.a10, ifb.a11}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Contiguous frame 0..15
    log0.delete();
    frame(16, 0, 1'b0);
    check_frame1("t1");

    // Same frame with random bubbles
    log0.delete();
    frame(16, 0, 1'b1);
    check_frame1("t2");

    // Signed extremes in the first window
    for (int i = 0; i < 16; i++) t3[i] = 9'($urandom);
    t3[0] = 9'h100; t3[1] = 9'h0FF; t3[4] = 9'h1FF; t3[5] = 9'h000;
    for (int i = 0; i < 6; i++) pix(t3[i], i == 0);
    @(posedge clk);
    #1;
    expect_eq("t3_valid", ifa.win_valid, 1);
    expect_eq("t3_a00", $unsigned(ifa.a00), 9'h100);
    expect_eq("t3_a01", $unsigned(ifa.a01), 9'h0FF);
    expect_eq("t3_a10", $unsigned(ifa.a10), 9'h1FF);
    expect_eq("t3_a11", $unsigned(ifa.a11), 9'h000);
    for (int i = 6; i < 16; i++) pix(t3[i], 1'b0);
    idle(2);

    // SOF reasserted at pixel index 6
    log0.delete();
    for (int i = 0; i < 6; i++) pix(9'(i), i == 0);
    frame(16, 100, 1'b0);
    expect_eq("t4_count", log0.size(), 5);
    expect_eq("t4_w0", log0[0], pk(0, 1, 4, 5, 0));
    expect_eq("t4_w1", log0[1], pk(100, 101, 104, 105, 0));
    expect_eq("t4_w4", log0[4], pk(110, 111, 114, 115, 1));

    // Reset mid-frame after pixel 9
    for (int i = 0; i < 10; i++) pix(9'(i), i == 0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("t5_rst4", {ifa.win_valid, ifa.win_last, ifa.a00, ifa.a01, ifa.a10, ifa.a11}, 0);
    expect_eq("t5_rst6", {ifb.win_valid, ifb.win_last, ifb.a00, ifb.a01, ifb.a10, ifb.a11}, 0);
    idle(1);
    rst_n = 1'b1;
    log0.delete();
    frame(16, 0, 1'b0);
    check_frame1("t5");

    // Two 6x2 frames back to back
    log1.delete();
    for (int i = 0; i < 12; i++) pix(9'(20 + i), i == 0);
    for (int i = 0; i < 12; i++) pix(9'(40 + i), i == 0);
    idle(2);
    expect_eq("t6_count", log1.size(), 6);
    expect_eq("t6_w0", log1[0], pk(20, 21, 26, 27, 0));
    expect_eq("t6_w2", log1[2], pk(24, 25, 30, 31, 1));
    expect_eq("t6_w3", log1[3], pk(40, 41, 46, 47, 0));
    expect_eq("t6_w5", log1[5], pk(44, 45, 50, 51, 1));

    // Random traffic with bubbles and occasional SOF
    repeat (2000) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else pix(9'($urandom), $urandom_range(0, 49) == 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
